// File: rtl/bias_act.sv
// bias_act: streams a feature map from DRAM through a saturating per-channel
// bias add and a selectable activation, writing each result back in place.
module bias_act #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int KNL_MAXNUM = 16,
  parameter int DIM_WIDTH  = 5,
  parameter int PARAM_BASE = 0,
  parameter int BIAS_BASE  = 61504,
  parameter int FMAP_BASE  = 131072,
  parameter int LEAK_SHIFT = 3,
  parameter logic signed [DATA_WIDTH-1:0] CLIP_MAX = DATA_WIDTH'(6 << 16)
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic [1:0]            act_mode,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  busy,
  output logic                  done
);
  localparam int CH_W = $clog2(KNL_MAXNUM);
  localparam logic [ADDR_WIDTH-1:0] PARAM_A = ADDR_WIDTH'(PARAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] BIAS_A  = ADDR_WIDTH'(BIAS_BASE);
  localparam logic [ADDR_WIDTH-1:0] FMAP_A  = ADDR_WIDTH'(FMAP_BASE);
  localparam logic [DIM_WIDTH:0]    DIM_ONE = (DIM_WIDTH+1)'(1);
  localparam logic [DIM_WIDTH:0]    DIM_MAX = (DIM_WIDTH+1)'(1 << DIM_WIDTH);
  localparam logic [CH_W:0]         DEP_ONE = (CH_W+1)'(1);
  localparam logic [CH_W:0]         DEP_MAX = (CH_W+1)'(KNL_MAXNUM);
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LD_PARAM, S_LD_BIAS, S_EVAL, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   mode_q, mode_d;
  logic [1:0]                   pcnt_q, pcnt_d;
  logic [CH_W-1:0]              c_q, c_d;
  logic [DIM_WIDTH-1:0]         h_q, h_d, w_q, w_d;
  logic [CH_W:0]                depth_q, depth_d;
  logic [DIM_WIDTH:0]           height_q, height_d, width_q, width_d;
  logic signed [DATA_WIDTH-1:0] bias_q [KNL_MAXNUM];
  logic [DATA_WIDTH-1:0]        data_out_q;
  logic [ADDR_WIDTH-1:0]        addr_out_q;
  logic                         wr_q;

  logic                         bias_we, pix_we;
  logic                         last_c, last_h, last_w;
  logic [DIM_WIDTH:0]           prm_raw, dim_sat;
  logic [CH_W:0]                depth_sat;
  logic signed [DATA_WIDTH-1:0] bias_sel, sum_sat, act_val;
  logic [DATA_WIDTH:0]          sum_ext;

  assign last_c = ({1'b0, c_q} == depth_q - DEP_ONE);
  assign last_h = ({1'b0, h_q} == height_q - DIM_ONE);
  assign last_w = ({1'b0, w_q} == width_q - DIM_ONE);

  // Only the low DIM_WIDTH+1 bits of a parameter word matter; zero and
  // oversize values are pulled into the legal range.
  always_comb begin
    prm_raw = data_in[DIM_WIDTH:0];
    if (prm_raw == '0)                    depth_sat = DEP_ONE;
    else if (int'(prm_raw) > KNL_MAXNUM)  depth_sat = DEP_MAX;
    else                                  depth_sat = (CH_W+1)'(prm_raw);
    if (prm_raw == '0)                          dim_sat = DIM_ONE;
    else if (int'(prm_raw) > (1 << DIM_WIDTH))  dim_sat = DIM_MAX;
    else                                        dim_sat = prm_raw;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pcnt_d     = pcnt_q;
    c_d        = c_q;
    h_d        = h_q;
    w_d        = w_q;
    depth_d    = depth_q;
    height_d   = height_q;
    width_d    = width_q;
    dram_en_rd = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    addr_in    = '0;
    bias_we    = 1'b0;
    pix_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) begin
          mode_d  = act_mode;
          pcnt_d  = '0;
          c_d     = '0;
          h_d     = '0;
          w_d     = '0;
          state_d = S_LD_PARAM;
        end
      end
      S_LD_PARAM: begin
        dram_en_rd = 1'b1;
        addr_in    = PARAM_A + ADDR_WIDTH'(pcnt_q);
        if (dram_valid) begin
          case (pcnt_q)
            2'd0:    depth_d  = depth_sat;
            2'd1:    height_d = dim_sat;
            default: width_d  = dim_sat;
          endcase
          if (pcnt_q == 2'd2) begin
            pcnt_d  = '0;
            state_d = S_LD_BIAS;
          end else begin
            pcnt_d = pcnt_q + 2'd1;
          end
        end
      end
      S_LD_BIAS: begin
        dram_en_rd = 1'b1;
        addr_in    = BIAS_A + ADDR_WIDTH'(c_q);
        if (dram_valid) begin
          bias_we = 1'b1;
          if (last_c) begin
            c_d     = '0;
            state_d = S_EVAL;
          end else begin
            c_d = c_q + CH_W'(1);
          end
        end
      end
      S_EVAL: begin
        dram_en_rd = 1'b1;
        addr_in    = FMAP_A + ADDR_WIDTH'({c_q, h_q, w_q});
        if (dram_valid) begin
          pix_we = 1'b1;
          if (!last_w) begin
            w_d = w_q + DIM_WIDTH'(1);
          end else begin
            w_d = '0;
            if (!last_h) begin
              h_d = h_q + DIM_WIDTH'(1);
            end else begin
              h_d = '0;
              if (!last_c) begin
                c_d = c_q + CH_W'(1);
              end else begin
                c_d     = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One extra bit of headroom exposes signed overflow of the bias add.
  always_comb begin
    bias_sel = bias_q[c_q];
    sum_ext  = {data_in[DATA_WIDTH-1], data_in} + {bias_sel[DATA_WIDTH-1], bias_sel};
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
      sum_sat = sum_ext[DATA_WIDTH] ? S_MIN : S_MAX;
    else
      sum_sat = sum_ext[DATA_WIDTH-1:0];
    act_val = sum_sat;
    case (mode_q)
      2'b01: if (sum_sat[DATA_WIDTH-1]) act_val = '0;
      2'b10: if (sum_sat[DATA_WIDTH-1]) act_val = sum_sat >>> LEAK_SHIFT;
      2'b11: begin
        if (sum_sat[DATA_WIDTH-1])    act_val = '0;
        else if (sum_sat > CLIP_MAX)  act_val = CLIP_MAX;
      end
      default: act_val = sum_sat;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      pcnt_q   <= '0;
      c_q      <= '0;
      h_q      <= '0;
      w_q      <= '0;
      depth_q  <= '0;
      height_q <= '0;
      width_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pcnt_q   <= pcnt_d;
      c_q      <= c_d;
      h_q      <= h_d;
      w_q      <= w_d;
      depth_q  <= depth_d;
      height_q <= height_d;
      width_q  <= width_d;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int i = 0; i < KNL_MAXNUM; i++) bias_q[i] <= '0;
    end else if (bias_we) begin
      bias_q[c_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      data_out_q <= '0;
      addr_out_q <= '0;
      wr_q       <= 1'b0;
    end else begin
      wr_q <= pix_we;
      if (pix_we) begin
        data_out_q <= act_val;
        addr_out_q <= addr_in;
      end
    end
  end

  assign data_out   = data_out_q;
  assign addr_out   = addr_out_q;
  assign dram_en_wr = wr_q;
endmodule

// File: tb/tb_bias_act.sv
// Randomised bench for bias_act: a DRAM responder with optional stalls,
// a scoreboard of expected writes and an independent arithmetic model.
`timescale 1ns/1ps
module tb_bias_act;
  localparam int     DW         = 32;
  localparam int     AW         = 18;
  localparam int     KMAX       = 16;
  localparam int     DIMW       = 5;
  localparam int     PARAM_BASE = 0;
  localparam int     BIAS_BASE  = 61504;
  localparam int     FMAP_BASE  = 131072;
  localparam int     LEAK       = 3;
  localparam longint LDIV       = 64'sd1 << LEAK;
  localparam longint CLIP       = 64'sd6 << 16;
  localparam longint SMAX       = 64'sh7FFF_FFFF;
  localparam longint SMIN       = -64'sh8000_0000;

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    act_mode = 2'b00;
  logic          dram_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_in, addr_out;
  logic          dram_en_rd, dram_en_wr, busy, done;

  bias_act dut (
    .clk(clk), .srstn(srstn), .enable(enable), .act_mode(act_mode),
    .dram_valid(dram_valid), .data_in(data_in), .data_out(data_out),
    .addr_in(addr_in), .addr_out(addr_out), .dram_en_rd(dram_en_rd),
    .dram_en_wr(dram_en_wr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] mem [int];
  bit            pat_q[$];
  int            stall_pct = 0;
  int            stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_0000 ^ 32'(a);
  endfunction

  function automatic int pa(input int c, input int y, input int x);
    return FMAP_BASE + c * (1 << (2 * DIMW)) + y * (1 << DIMW) + x;
  endfunction

  function automatic int eff_depth(input logic [DW-1:0] raw);
    int v;
    v = int'(raw % 64);
    return (v == 0) ? 1 : ((v > KMAX) ? KMAX : v);
  endfunction

  function automatic int eff_dim(input logic [DW-1:0] raw);
    int v;
    v = int'(raw % 64);
    return (v == 0) ? 1 : ((v > (1 << DIMW)) ? (1 << DIMW) : v);
  endfunction

  function automatic logic [DW-1:0] ref_val(input logic [DW-1:0] pix, input logic [DW-1:0] b,
                                            input logic [1:0] m);
    longint s;
    s = longint'($signed(pix)) + longint'($signed(b));
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    case (m)
      2'b01: if (s < 0) s = 0;
      2'b10: if (s < 0) s = -((-s + LDIV - 1) / LDIV);
      2'b11: begin
        if (s < 0) s = 0;
        if (s > CLIP) s = CLIP;
      end
      default: ;
    endcase
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 400)) - 32'd200;
      1:       return 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
      2:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
      3:       return 32'($urandom_range(0, 8 << 16));
      default: return $urandom;
    endcase
  endfunction

  task automatic fill_random(input int d, input int h, input int w);
    for (int c = 0; c < d; c++) begin
      mem[BIAS_BASE + c] = rand_word();
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) mem[pa(c, y, x)] = rand_word();
    end
  endtask

  task automatic push_expect(input int d, input int h, input int w, input logic [1:0] m);
    for (int c = 0; c < d; c++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          wr_t e;
          e.a = AW'(pa(c, y, x));
          e.d = ref_val(rd(pa(c, y, x)), rd(BIAS_BASE + c), m);
          exp_q.push_back(e);
        end
  endtask

  // DRAM responder: data follows addr_in, optional stalls, hold check.
  initial begin : responder
    logic [AW-1:0] prev_a;
    bit            prev_stall;
    prev_a     = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (srstn && dram_en_rd && prev_stall) chk("addr_hold", addr_in, prev_a);
      if (dram_en_rd && pat_q.size() > 0 && int'(addr_in) >= FMAP_BASE)
        dram_valid = pat_q.pop_front();
      else if (stall_pct > 0)
        dram_valid = ($urandom_range(0, 99) >= stall_pct);
      else
        dram_valid = 1'b1;
      data_in    = rd(int'(addr_in));
      prev_stall = srstn && dram_en_rd && !dram_valid;
      prev_a     = addr_in;
      if (prev_stall) stall_cnt++;
    end
  end

  // Scoreboard monitor: every write must match the head of the queue.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (srstn && dram_en_wr) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_write: got write addr %0h data %0h, required none", addr_out, data_out);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addr_out, e.a);
          chk("wr_data", data_out, e.d);
        end
      end
    end
  end

  task automatic start_pass(input logic [DW-1:0] pd, input logic [DW-1:0] ph, input logic [DW-1:0] pw,
                            input logic [1:0] m, output int t0);
    mem[PARAM_BASE]     = pd;
    mem[PARAM_BASE + 1] = ph;
    mem[PARAM_BASE + 2] = pw;
    push_expect(eff_depth(pd), eff_dim(ph), eff_dim(pw), m);
    @(negedge clk);
    stall_cnt = 0;
    enable    = 1'b1;
    act_mode  = m;
    t0        = cyc;
    @(negedge clk);
    enable   = 1'b0;
    act_mode = 2'($urandom);
  endtask

  task automatic finish_pass(input string tag, input int d, input int h, input int w,
                             input int t0, input bit poke);
    bit seen;
    int lat;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        enable = poke && (i == 3);
        @(negedge clk);
      end
    end
    enable = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen, required within 40000 cycles", tag);
      exp_q.delete();
      return;
    end
    chk({tag, "_latency"}, lat, 1 + 3 + d + d * h * w + stall_cnt);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
    $display("[TB] pass %s D=%0d H=%0d W=%0d stalls=%0d latency=%0d", tag, d, h, w, stall_cnt, lat);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_addr_out"}, addr_out, 0);
    chk({tag, "_en_wr"}, dram_en_wr, 0);
    chk({tag, "_en_rd"}, dram_en_rd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic random_pass(input string tag, input logic [DW-1:0] pd, input logic [DW-1:0] ph,
                             input logic [DW-1:0] pw, input logic [1:0] m, input bit poke);
    int t0;
    fill_random(eff_depth(pd), eff_dim(ph), eff_dim(pw));
    start_pass(pd, ph, pw, m, t0);
    finish_pass(tag, eff_depth(pd), eff_dim(ph), eff_dim(pw), t0, poke);
  endtask

  function automatic logic [DW-1:0] raw_small();
    return ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 4));
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    bit ok;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    srstn = 1'b1;
    @(negedge clk);

    // Directed ReLU pass: params (2,2,2), biases {5,-10}, pixels 0..7.
    mem[BIAS_BASE]     = 32'd5;
    mem[BIAS_BASE + 1] = 32'hFFFF_FFF6;
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++) mem[pa(c, y, x)] = 32'(c * 4 + y * 2 + x);
    start_pass(32'd2, 32'd2, 32'd2, 2'b01, t0);
    finish_pass("relu", 2, 2, 2, t0, 1'b0);

    // Same pass with a 1,0,0,1 valid pattern in EVAL.
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    start_pass(32'd2, 32'd2, 32'd2, 2'b01, t0);
    finish_pass("relu_stall", 2, 2, 2, t0, 1'b0);
    chk("stall_count", stall_cnt, 2);

    // Leaky and clipped activation corners.
    mem[BIAS_BASE] = 32'd0;
    mem[pa(0, 0, 0)] = 32'hFFFF_FFC0;
    mem[pa(0, 0, 1)] = 32'd64;
    start_pass(32'd1, 32'd1, 32'd2, 2'b10, t0);
    finish_pass("leaky", 1, 1, 2, t0, 1'b0);
    mem[pa(0, 0, 0)] = 32'd7 << 16;
    mem[pa(0, 0, 1)] = 32'hFFFF_FFFF;
    start_pass(32'd1, 32'd1, 32'd2, 2'b11, t0);
    finish_pass("clip", 1, 1, 2, t0, 1'b0);

    // Saturation at both ends.
    mem[BIAS_BASE]     = 32'h7FFF_FFF0;
    mem[BIAS_BASE + 1] = 32'h8000_0000;
    mem[pa(0, 0, 0)]   = 32'h0000_0100;
    mem[pa(1, 0, 0)]   = 32'hFFFF_FFFF;
    start_pass(32'd2, 32'd1, 32'd1, 2'b00, t0);
    finish_pass("sat", 2, 1, 1, t0, 1'b0);

    // Depth clamping, enable poked while busy.
    random_pass("depth0", 32'd0, 32'd3, 32'd3, 2'($urandom), 1'b1);
    mem[BIAS_BASE + KMAX] = 32'h1234_5678;
    random_pass("depth40", 32'd40, 32'd1, 32'd2, 2'($urandom), 1'b0);

    // Randomised passes with stalls and junk upper parameter bits.
    stall_pct = 25;
    for (int k = 0; k < 8; k++) begin
      logic [DW-1:0] pd, ph, pw;
      pd = raw_small();
      ph = raw_small();
      pw = raw_small();
      if (k == 3) pd = 32'hABCD_0032;
      if (k == 5) pw = 32'd40;
      if (k == 6) ph = 32'hFFFF_FFC0;
      random_pass($sformatf("rand%0d", k), pd, ph, pw, 2'($urandom), k[0]);
    end
    stall_pct = 0;

    // Reset in the middle of EVAL, with enable pulsed while busy.
    fill_random(3, 4, 4);
    start_pass(32'd3, 32'd4, 32'd4, 2'b10, t0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (int'(addr_in) >= FMAP_BASE) ok = 1'b1;
      else @(negedge clk);
    end
    chk("reach_eval", ok, 1'b1);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    #2 srstn = 1'b0;
    #1 chk_reset_vals("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_busy", busy, 1'b0);
    end
    random_pass("after_reset", 32'd2, 32'd3, 32'd2, 2'b11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
